ifetch: RTL and testbench

- Instruction fetch stage; initiator side of the instruction-memory interface.
- Owns the PC register and drives the fetch address every cycle.
- Captures the 32-bit instruction word returned combinationally by instruction memory into an IF/ID register.
- Hands that register to decode over a valid/ready handshake; supports branch/jump redirect, decode backpressure, and fault halting on bad PCs.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_if.sv | 13 +
 rtl/ifetch.sv | 91 +++++++++
 tb/tb_ifetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared fetch-stage definitions
// Purpose: datapath width, the NOP encoding and the fetch state type.
// Ports: none (package).
package ifetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0: the canonical RISC-V NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction-memory interface with fetch and memory sides
// Purpose: carries the fetch address out and the instruction word back.
// Ports: imem_pc (fetch -> memory), imem_instruction (memory -> fetch, same cycle).
interface imem_if;
  import ifetch_pkg::*;

  logic [XLEN-1:0] imem_pc;
  logic [31:0]     imem_instruction;

  modport fetch  (output imem_pc, input  imem_instruction);
  modport memory (input  imem_pc, output imem_instruction);

endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with PC, IF/ID register and redirect
// Purpose: owns pc_q, fetches from instruction memory, presents one entry to
//   decode over id_valid/id_ready, halts after loading a fault entry.
// Ports: clk, rst_n (async active-low); imem (fetch side of imem_if);
//   redirect_valid/redirect_pc from execute; id_ready from decode;
//   id_valid/id_instr/id_pc/id_fault IF/ID entry; fetch_count accepted entries.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              MEM_BYTES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_if.fetch           imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault,
  output logic [31:0]     fetch_count
);

  // Highest PC whose full 4-byte word lies inside memory
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic            advance;
  logic            fault_pc;

  assign imem.imem_pc = pc_q;

  // The IF/ID slot can be (re)loaded when empty or being consumed this cycle
  assign advance  = !id_valid || id_ready;
  assign fault_pc = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_fault    <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Acceptance is counted before any flush: an entry taken by decode on
      // the same edge as a redirect was genuinely delivered.
      if (id_valid && id_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (redirect_valid) begin
        // Flush even under backpressure; the held entry is wrong-path
        id_valid <= 1'b0;
        pc_q     <= redirect_pc;
        state    <= RUN;
      end else begin
        case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (advance) begin
              id_valid <= 1'b1;
              id_pc    <= pc_q;
              if (fault_pc) begin
                // pc_q stays put so the faulting address remains visible
                id_fault <= 1'b1;
                id_instr <= NOP_INSTR;
                state    <= HALT;
              end else begin
                id_fault <= 1'b0;
                id_instr <= imem.imem_instruction;
                pc_q     <= pc_q + XLEN'(4);
              end
            end
          end
          HALT: begin
            if (advance) begin
              id_valid <= 1'b0;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;
  import ifetch_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_fault;
  logic [31:0]     fetch_count;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:1023];

  imem_if imem_bus ();

  assign imem_bus.imem_instruction = mem[imem_bus.imem_pc[11:2]];

  ifetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus.fetch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_fault       (id_fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input logic f);
    chk({tag, ".valid"}, 64'(id_valid), 64'(v));
    chk({tag, ".instr"}, 64'(id_instr), 64'(ins));
    chk({tag, ".pc"},    64'(id_pc),    64'(pc));
    chk({tag, ".fault"}, 64'(id_fault), 64'(f));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | (i << 2);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;

    step();
    step();
    chk_entry("reset", 1'b0, 32'h0000_0013, 32'h0, 1'b0);
    chk("reset.count", 64'(fetch_count), 64'd0);
    chk("reset.imem_pc", 64'(imem_bus.imem_pc), 64'h0);

    rst_n = 1'b1;
    step();                                   // BOOT edge
    chk("boot.valid", 64'(id_valid), 64'd0);
    step();                                   // first capture
    chk_entry("first", 1'b1, 32'h0050_0093, 32'h0, 1'b0);
    step();
    chk_entry("second", 1'b1, 32'h00A0_0113, 32'h4, 1'b0);
    chk("second.count", 64'(fetch_count), 64'd1);
    step();
    chk_entry("third", 1'b1, 32'hC000_0008, 32'h8, 1'b0);
    chk("third.count", 64'(fetch_count), 64'd2);

    // Decode backpressure for three edges
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_entry("stall", 1'b1, 32'hC000_0008, 32'h8, 1'b0);
      chk("stall.imem_pc", 64'(imem_bus.imem_pc), 64'hC);
      chk("stall.count", 64'(fetch_count), 64'd2);
    end
    id_ready = 1'b1;
    step();
    chk_entry("resume", 1'b1, 32'hC000_000C, 32'hC, 1'b0);
    chk("resume.count", 64'(fetch_count), 64'd3);

    // Redirect while stalled: held entry at 0xC is dropped, not counted
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("redir.valid", 64'(id_valid), 64'd0);
    chk("redir.imem_pc", 64'(imem_bus.imem_pc), 64'h40);
    chk("redir.count", 64'(fetch_count), 64'd3);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    chk_entry("target", 1'b1, 32'hC000_0040, 32'h40, 1'b0);
    chk("target.count", 64'(fetch_count), 64'd3);
    step();
    chk_entry("target2", 1'b1, 32'hC000_0044, 32'h44, 1'b0);
    chk("target2.count", 64'(fetch_count), 64'd4);

    // Misaligned redirect: one fault entry then HALT
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    chk("mis.flush", 64'(id_valid), 64'd0);
    chk("mis.count", 64'(fetch_count), 64'd5);
    redirect_valid = 1'b0;
    step();
    chk_entry("mis.fault", 1'b1, 32'h0000_0013, 32'h42, 1'b1);
    step();
    chk("halt.valid", 64'(id_valid), 64'd0);
    chk("halt.count", 64'(fetch_count), 64'd6);
    step();
    chk("halt2.valid", 64'(id_valid), 64'd0);
    chk("halt2.imem_pc", 64'(imem_bus.imem_pc), 64'h42);

    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    chk("unhalt.valid", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    step();
    chk_entry("unhalt", 1'b1, 32'hC000_0010, 32'h10, 1'b0);

    // Run off the end of memory
    redirect_valid = 1'b1;
    redirect_pc = 32'hFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk_entry("end.ff8", 1'b1, 32'hC000_0FF8, 32'hFF8, 1'b0);
    step();
    chk_entry("end.ffc", 1'b1, 32'hC000_0FFC, 32'hFFC, 1'b0);
    step();
    chk_entry("end.fault", 1'b1, 32'h0000_0013, 32'h1000, 1'b1);
    step();
    chk("end.halt", 64'(id_valid), 64'd0);
    chk("end.count", 64'(fetch_count), 64'd10);

    // Asynchronous reset mid-stream
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    chk_entry("pre_rst", 1'b1, 32'h0050_0093, 32'h0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_entry("async_rst", 1'b0, 32'h0000_0013, 32'h0, 1'b0);
    chk("async_rst.count", 64'(fetch_count), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_boot.valid", 64'(id_valid), 64'd0);
    step();
    chk_entry("rst_first", 1'b1, 32'h0050_0093, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
